// File: rtl/riscv_ctrl_pkg.sv
// Shared constants and types for the multicycle RV32I control path.
// Holds the FSM state enum, opcodes, ALUOp codes, mux selects and ImmSrc codes.
package riscv_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10
   } state_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic [1:0] ALUOP_ADD  = 2'b00;
   localparam logic [1:0] ALUOP_SUB  = 2'b01;
   localparam logic [1:0] ALUOP_FUNC = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   // One-hot opcode class; all zero means unsupported opcode.
   typedef struct packed {
      logic lw;
      logic sw;
      logic r;
      logic i;
      logic beq;
      logic jal;
   } op_class_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode decode: immediate format select and one-hot class.
// Ports: i_opcode (7) in; o_imm_src (2) out; o_class (op_class_t) out.
module instr_decoder
   import riscv_ctrl_pkg::*;
(
   input  logic [6:0] i_opcode,
   output logic [1:0] o_imm_src,
   output op_class_t  o_class
);

   always_comb begin
      o_imm_src = IMM_I;
      o_class   = '0;
      case (i_opcode)
         OP_LW: begin
            o_class.lw = 1'b1;
         end
         OP_SW: begin
            o_class.sw = 1'b1;
            o_imm_src  = IMM_S;
         end
         OP_R: begin
            o_class.r = 1'b1;
         end
         OP_I: begin
            o_class.i = 1'b1;
         end
         OP_BEQ: begin
            o_class.beq = 1'b1;
            o_imm_src   = IMM_B;
         end
         OP_JAL: begin
            o_class.jal = 1'b1;
            o_imm_src   = IMM_J;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle RV32I core (Moore, 3-5 cycles/instr).
// In: clk, reset (sync, high), opcode[7], zero, mem_ready.
// Out: mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ALUSrcA[2],
//      ALUSrcB[2], ALUOp[2], ResultSrc[2], ImmSrc[2], illegal_op, state_o[4].
module multicycle_control
   import riscv_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       MemWrite,
   output logic       AdrSrc,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic       RegWrite,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] ResultSrc,
   output logic [1:0] ImmSrc,
   output logic       illegal_op,
   output logic [3:0] state_o
);

   state_t    r_state;
   state_t    w_state;
   state_t    w_next;
   op_class_t w_class;

   logic       w_mem_req;
   logic       w_mem_write;
   logic       w_adr_src;
   logic       w_ir_write;
   logic       w_pc_update;
   logic       w_branch;
   logic       w_reg_write;
   logic       w_illegal;
   logic [1:0] w_src_a;
   logic [1:0] w_src_b;
   logic [1:0] w_alu_op;
   logic [1:0] w_res_src;

   instr_decoder u_dec (
      .i_opcode  (opcode),
      .o_imm_src (ImmSrc),
      .o_class   (w_class)
   );

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_FETCH;
      else       r_state <= w_next;
   end

   // Reset presents FETCH immediately, even before the register clears.
   assign w_state = reset ? S_FETCH : r_state;

   always_comb begin
      w_next      = S_FETCH;
      w_mem_req   = 1'b0;
      w_mem_write = 1'b0;
      w_adr_src   = 1'b0;
      w_ir_write  = 1'b0;
      w_pc_update = 1'b0;
      w_branch    = 1'b0;
      w_reg_write = 1'b0;
      w_illegal   = 1'b0;
      w_src_a     = SRCA_PC;
      w_src_b     = SRCB_RS2;
      w_alu_op    = ALUOP_ADD;
      w_res_src   = RES_ALUOUT;
      unique case (w_state)
         S_FETCH: begin
            w_mem_req   = 1'b1;
            w_src_b     = SRCB_FOUR;
            w_res_src   = RES_ALURESULT;
            w_ir_write  = mem_ready;
            w_pc_update = mem_ready;
            w_next      = mem_ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            w_src_a = SRCA_OLDPC;
            w_src_b = SRCB_IMM;
            unique case (1'b1)
               w_class.lw,
               w_class.sw:  w_next = S_MEMADR;
               w_class.r:   w_next = S_EXECUTER;
               w_class.i:   w_next = S_EXECUTEI;
               w_class.beq: w_next = S_BEQ;
               w_class.jal: w_next = S_JAL;
               default: begin
                  w_next    = S_FETCH;
                  w_illegal = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            w_src_a = SRCA_RS1;
            w_src_b = SRCB_IMM;
            w_next  = w_class.lw ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            w_mem_req = 1'b1;
            w_adr_src = 1'b1;
            w_next    = mem_ready ? S_MEMWB : S_MEMREAD;
         end
         S_MEMWB: begin
            w_res_src   = RES_DATA;
            w_reg_write = 1'b1;
            w_next      = S_FETCH;
         end
         S_MEMWRITE: begin
            w_mem_req   = 1'b1;
            w_adr_src   = 1'b1;
            w_mem_write = 1'b1;
            w_next      = mem_ready ? S_FETCH : S_MEMWRITE;
         end
         S_EXECUTER: begin
            w_src_a  = SRCA_RS1;
            w_src_b  = SRCB_RS2;
            w_alu_op = ALUOP_FUNC;
            w_next   = S_ALUWB;
         end
         S_EXECUTEI: begin
            w_src_a  = SRCA_RS1;
            w_src_b  = SRCB_IMM;
            w_alu_op = ALUOP_FUNC;
            w_next   = S_ALUWB;
         end
         S_ALUWB: begin
            w_res_src   = RES_ALUOUT;
            w_reg_write = 1'b1;
            w_next      = S_FETCH;
         end
         S_BEQ: begin
            w_src_a  = SRCA_RS1;
            w_src_b  = SRCB_RS2;
            w_alu_op = ALUOP_SUB;
            w_branch = 1'b1;
            w_next   = S_FETCH;
         end
         S_JAL: begin
            w_src_a     = SRCA_OLDPC;
            w_src_b     = SRCB_FOUR;
            w_pc_update = 1'b1;
            w_next      = S_ALUWB;
         end
         default: begin
            w_next = S_FETCH;
         end
      endcase
   end

   // Strobes are squashed during reset so an in-flight access is abandoned.
   assign mem_req    = w_mem_req & ~reset;
   assign MemWrite   = w_mem_write & ~reset;
   assign IRWrite    = w_ir_write & ~reset;
   assign RegWrite   = w_reg_write & ~reset;
   assign illegal_op = w_illegal & ~reset;
   assign PCWrite    = ~reset &
                       (w_pc_update | (w_branch & zero));

   assign AdrSrc    = w_adr_src;
   assign ALUSrcA   = w_src_a;
   assign ALUSrcB   = w_src_b;
   assign ALUOp     = w_alu_op;
   assign ResultSrc = w_res_src;
   assign state_o   = w_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed vector table
// followed by randomized instruction streams against a path-level model.
module tb_multicycle_control;

   localparam logic [6:0] LW  = 7'b0000011;
   localparam logic [6:0] SW  = 7'b0100011;
   localparam logic [6:0] RT  = 7'b0110011;
   localparam logic [6:0] IT  = 7'b0010011;
   localparam logic [6:0] BQ  = 7'b1100011;
   localparam logic [6:0] JL  = 7'b1101111;
   localparam logic [6:0] BAD = 7'b1111111;

   // strobe vector: {mem_req, MemWrite, IRWrite, PCWrite, RegWrite, illegal}
   localparam logic [5:0] X_NO = 6'b000000;
   localparam logic [5:0] X_FE = 6'b101100;
   localparam logic [5:0] X_FW = 6'b100000;
   localparam logic [5:0] X_MR = 6'b100000;
   localparam logic [5:0] X_MW = 6'b110000;
   localparam logic [5:0] X_WB = 6'b000010;
   localparam logic [5:0] X_PC = 6'b000100;
   localparam logic [5:0] X_IL = 6'b000001;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] opcode;
   logic       zero;
   logic       mem_ready;
   logic       mem_req;
   logic       MemWrite;
   logic       AdrSrc;
   logic       IRWrite;
   logic       PCWrite;
   logic       RegWrite;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ALUOp;
   logic [1:0] ResultSrc;
   logic [1:0] ImmSrc;
   logic       illegal_op;
   logic [3:0] state_o;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       rst;
      logic [6:0] op;
      logic       z;
      logic       rdy;
      logic [3:0] st;
      logic [5:0] stb;
   } vec_t;

   vec_t tbl[$];

   multicycle_control dut (
      .clk        (clk),
      .reset      (reset),
      .opcode     (opcode),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .mem_req    (mem_req),
      .MemWrite   (MemWrite),
      .AdrSrc     (AdrSrc),
      .IRWrite    (IRWrite),
      .PCWrite    (PCWrite),
      .RegWrite   (RegWrite),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ALUOp      (ALUOp),
      .ResultSrc  (ResultSrc),
      .ImmSrc     (ImmSrc),
      .illegal_op (illegal_op),
      .state_o    (state_o)
   );

   always #5 clk = ~clk;

   // Per-state datapath controls: {AdrSrc, ALUSrcA, ALUSrcB, ALUOp, ResultSrc}
   function automatic logic [8:0] ctl_of(input logic [3:0] s);
      case (s)
         4'd0:    return 9'b0_00_10_00_10;
         4'd1:    return 9'b0_01_01_00_00;
         4'd2:    return 9'b0_10_01_00_00;
         4'd3:    return 9'b1_00_00_00_00;
         4'd4:    return 9'b0_00_00_00_01;
         4'd5:    return 9'b1_00_00_00_00;
         4'd6:    return 9'b0_10_00_10_00;
         4'd7:    return 9'b0_10_01_10_00;
         4'd8:    return 9'b0_00_00_00_00;
         4'd9:    return 9'b0_10_00_01_00;
         4'd10:   return 9'b0_01_10_00_00;
         default: return 9'b0_00_00_00_00;
      endcase
   endfunction

   function automatic logic [1:0] imm_of(input logic [6:0] op);
      case (op)
         SW:      return 2'b01;
         BQ:      return 2'b10;
         JL:      return 2'b11;
         default: return 2'b00;
      endcase
   endfunction

   function automatic bit legal(input logic [6:0] op);
      return op inside {LW, SW, RT, IT, BQ, JL};
   endfunction

   function automatic vec_t v(input logic rst, input logic [6:0] op,
                              input logic z, input logic rdy,
                              input int st, input logic [5:0] stb);
      vec_t r;
      r.rst = rst;
      r.op  = op;
      r.z   = z;
      r.rdy = rdy;
      r.st  = 4'(st);
      r.stb = stb;
      return r;
   endfunction

   task automatic chk(input string nm, input int tag,
                      input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0d: got %0h want %0h", nm, tag, act, exp);
      end
   endtask

   task automatic step(input logic rst, input logic [6:0] op,
                       input logic z, input logic rdy);
      @(negedge clk);
      reset     = rst;
      opcode    = op;
      zero      = z;
      mem_ready = rdy;
      #1;
   endtask

   task automatic check_all(input string nm, input int tag,
                            input logic [3:0] st, input logic [5:0] stb);
      chk({nm, ".state"}, tag, 32'(state_o), 32'(st));
      chk({nm, ".strobe"}, tag,
          32'({mem_req, MemWrite, IRWrite, PCWrite, RegWrite, illegal_op}),
          32'(stb));
      chk({nm, ".ctl"}, tag,
          32'({AdrSrc, ALUSrcA, ALUSrcB, ALUOp, ResultSrc}),
          32'(ctl_of(st)));
      chk({nm, ".imm"}, tag, 32'(ImmSrc), 32'(imm_of(opcode)));
   endtask

   // Path-level model: each instruction is a fixed list of states, with
   // memory states (0,3,5) repeating while mem_ready is low.
   task automatic run_instr(input int kind, input int tag);
      logic [6:0] op;
      logic       z;
      logic       rdy;
      int         path[$];
      int         ws;
      bit         done;
      logic [5:0] e;
      case (kind)
         0: begin op = LW; path = '{0, 1, 2, 3, 4}; end
         1: begin op = SW; path = '{0, 1, 2, 5}; end
         2: begin op = RT; path = '{0, 1, 6, 8}; end
         3: begin op = IT; path = '{0, 1, 7, 8}; end
         4: begin op = BQ; path = '{0, 1, 9}; end
         5: begin op = JL; path = '{0, 1, 10, 8}; end
         default: begin
            op = 7'($urandom_range(0, 127));
            while (legal(op)) op = 7'($urandom_range(0, 127));
            path = '{0, 1};
         end
      endcase
      z = 1'($urandom_range(0, 1));
      foreach (path[k]) begin
         ws   = 0;
         done = 0;
         while (!done) begin
            rdy = (ws >= 3) ? 1'b1 : ($urandom_range(0, 3) != 0);
            step(1'b0, op, z, rdy);
            e[5] = (path[k] == 0) || (path[k] == 3) || (path[k] == 5);
            e[4] = (path[k] == 5);
            e[3] = (path[k] == 0) && rdy;
            e[2] = ((path[k] == 0) && rdy) || (path[k] == 10) ||
                   ((path[k] == 9) && z);
            e[1] = (path[k] == 4) || (path[k] == 8);
            e[0] = (path[k] == 1) && (kind == 6);
            check_all("rnd", tag, 4'(path[k]), e);
            if (e[5] && !rdy) ws++;
            else done = 1;
         end
      end
   endtask

   initial begin
      reset     = 1'b1;
      opcode    = LW;
      zero      = 1'b0;
      mem_ready = 1'b1;

      // reset
      tbl.push_back(v(1, LW, 0, 1, 0, X_NO));
      tbl.push_back(v(1, LW, 1, 1, 0, X_NO));
      // lw with a read stall; zero/mem_ready ignored elsewhere
      tbl.push_back(v(0, LW, 1, 1, 0, X_FE));
      tbl.push_back(v(0, LW, 0, 0, 1, X_NO));
      tbl.push_back(v(0, LW, 1, 1, 2, X_NO));
      tbl.push_back(v(0, LW, 0, 0, 3, X_MR));
      tbl.push_back(v(0, LW, 0, 1, 3, X_MR));
      tbl.push_back(v(0, LW, 1, 1, 4, X_WB));
      // R-type with a fetch stall
      tbl.push_back(v(0, RT, 0, 0, 0, X_FW));
      tbl.push_back(v(0, RT, 0, 1, 0, X_FE));
      tbl.push_back(v(0, RT, 0, 1, 1, X_NO));
      tbl.push_back(v(0, RT, 1, 0, 6, X_NO));
      tbl.push_back(v(0, RT, 0, 1, 8, X_WB));
      // I-type
      tbl.push_back(v(0, IT, 0, 1, 0, X_FE));
      tbl.push_back(v(0, IT, 0, 1, 1, X_NO));
      tbl.push_back(v(0, IT, 0, 1, 7, X_NO));
      tbl.push_back(v(0, IT, 0, 1, 8, X_WB));
      // beq taken / not taken
      tbl.push_back(v(0, BQ, 0, 1, 0, X_FE));
      tbl.push_back(v(0, BQ, 1, 1, 1, X_NO));
      tbl.push_back(v(0, BQ, 1, 1, 9, X_PC));
      tbl.push_back(v(0, BQ, 1, 1, 0, X_FE));
      tbl.push_back(v(0, BQ, 0, 1, 1, X_NO));
      tbl.push_back(v(0, BQ, 0, 1, 9, X_NO));
      // sw with three write stalls
      tbl.push_back(v(0, SW, 0, 1, 0, X_FE));
      tbl.push_back(v(0, SW, 0, 1, 1, X_NO));
      tbl.push_back(v(0, SW, 0, 1, 2, X_NO));
      tbl.push_back(v(0, SW, 0, 0, 5, X_MW));
      tbl.push_back(v(0, SW, 0, 0, 5, X_MW));
      tbl.push_back(v(0, SW, 0, 0, 5, X_MW));
      tbl.push_back(v(0, SW, 0, 1, 5, X_MW));
      // illegal opcode
      tbl.push_back(v(0, BAD, 0, 1, 0, X_FE));
      tbl.push_back(v(0, BAD, 1, 1, 1, X_IL));
      // reset in the middle of a store
      tbl.push_back(v(0, SW, 1, 1, 0, X_FE));
      tbl.push_back(v(0, SW, 0, 1, 1, X_NO));
      tbl.push_back(v(0, SW, 0, 1, 2, X_NO));
      tbl.push_back(v(0, SW, 0, 0, 5, X_MW));
      tbl.push_back(v(1, SW, 0, 0, 0, X_NO));
      // jal
      tbl.push_back(v(0, JL, 1, 1, 0, X_FE));
      tbl.push_back(v(0, JL, 0, 1, 1, X_NO));
      tbl.push_back(v(0, JL, 0, 1, 10, X_PC));
      tbl.push_back(v(0, JL, 1, 1, 8, X_WB));

      foreach (tbl[i]) begin
         step(tbl[i].rst, tbl[i].op, tbl[i].z, tbl[i].rdy);
         check_all("vec", i, tbl[i].st, tbl[i].stb);
      end

      for (int n = 0; n < 300; n++) begin
         run_instr($urandom_range(0, 6), n);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle RV32I core. It sequences the shared ALU, instruction/data memory port, register file and PC over 3–5 cycles per instruction. It drives the 2-bit ALUOp code consumed by the existing ALU control decoder: 00 = add, 01 = subtract, 10 = decode from func3/func7. Supported opcodes are lw, sw, R-type, I-type ALU, beq and jal.

## Interface
Parameters:
- none (all encodings are fixed constants in the shared package)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- opcode  in  7  instruction[6:0], taken from the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- mem_req  out  1  memory access request
- MemWrite  out  1  write strobe, level-held while the store is pending
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- IRWrite  out  1  instruction register load enable
- PCWrite  out  1  PC load enable, equal to PCUpdate | (Branch & zero)
- RegWrite  out  1  register file write enable
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1
- ALUSrcB  out  2  00 = rs2, 01 = imm, 10 = constant 4
- ALUOp  out  2  to ALU control
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- ImmSrc  out  2  combinational from opcode: lw/I-type 00, sw 01, beq 10, jal 11, others 00
- illegal_op  out  1  one-cycle pulse on an unknown opcode
- state_o  out  4  current state, for debug and bench

## Operation
- The FSM is Moore; outputs decode from the state register. The only exceptions are the mem_ready gating and PCWrite.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9, JAL 10. Codes 11–15 are unreachable and recover to FETCH.
- Any output not listed for a state is 0.
- FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite and PCUpdate are asserted only when mem_ready=1. The FSM stays in FETCH while mem_ready=0 and moves to DECODE when it is 1.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (computes the branch target). Next state by opcode:
  - 0000011 and 0100011 → MEMADR
  - 0110011 → EXECUTER
  - 0010011 → EXECUTEI
  - 1100011 → BEQ
  - 1101111 → JAL
  - any other opcode → FETCH, with illegal_op=1 for this cycle
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Goes to MEMREAD if opcode is lw, else to MEMWRITE.
- MEMREAD: mem_req=1, AdrSrc=1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Then goes to FETCH.
- MEMWRITE: mem_req=1, AdrSrc=1, MemWrite=1. Waits for mem_ready, then goes to FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Then goes to ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Then goes to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Then goes to FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Then goes to FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Then goes to ALUWB.
- Branch and PCUpdate are internal signals. PCWrite is combinational from them and zero.

## Timing
- Reset:
  - On any clk edge with reset=1, state becomes FETCH, overriding any transition.
  - While reset=1, the outputs mem_req, MemWrite, IRWrite, PCWrite, RegWrite and illegal_op are forced to 0.
  - All other outputs take FETCH values; state_o=0.
  - Reset mid-access (MEMWRITE/MEMREAD) abandons the access: MemWrite drops in the same cycle that reset is high.
- Latency with mem_ready=1 every cycle:
  - lw: 5 cycles
  - sw, R-type, I-type: 4 cycles
  - jal: 4 cycles
  - beq: 3 cycles
  - illegal opcode: 2 cycles
- Each mem_ready=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle. The FSM sits in the wait state with outputs stable and strobes gated.
- mem_ready outside a memory state is ignored.
- opcode is sampled in DECODE and MEMADR only. It must be stable from the cycle after IRWrite until the next FETCH.
- In BEQ, PCWrite follows zero in the same cycle; zero is valid combinationally in that state.

## Structure
- Shared package `riscv_ctrl_pkg` holds:
  - state enum (4-bit)
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL)
  - ALUOp codes (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNC=10)
  - ALUSrcA/B and ResultSrc select constants
- One sub-module, `instr_decoder`: combinational opcode → ImmSrc plus a one-hot opcode class that feeds the DECODE transition.
- The FSM register and output decode stay in the top block.

## Test plan
- Reset, then lw (0000011) with mem_ready=1:
  - state_o sequence 0, 1, 2, 3, 4, 0
  - IRWrite=1 and PCWrite=1 in cycle 0
  - RegWrite=1 only in the cycle where state_o=4
  - ALUOp=00 throughout
- R-type (0110011): state_o sequence 0, 1, 6, 8, 0, with ALUOp=10 in state 6 and RegWrite=1 in state 8. Repeat with I-type (0010011) and check state 7 uses ALUSrcB=01.
- beq (1100011) with zero=1, then again with zero=0:
  - state 9 has ALUOp=01
  - PCWrite=1 in state 9 when zero=1, PCWrite=0 when zero=0
  - returns to state 0 after 3 cycles in both cases
- sw (0100011) with mem_ready held 0 for 3 cycles in MEMWRITE:
  - state stays 5 for 4 cycles with MemWrite=1
  - ImmSrc=01
  - then state 0
- Opcode 1111111: state_o sequence 0, 1, 0, with illegal_op=1 only in the DECODE cycle and no RegWrite or PCWrite after FETCH.
- Assert reset during MEMWRITE: on the same cycle MemWrite=0 and mem_req=0; next cycle state_o=0. Then jal (1101111) gives 0, 1, 10, 8, 0, with PCWrite=1 in state 10.
